// File: rtl/topk_pkg.sv
// Shared constants and FSM state type for the top-K selector.
package topk_pkg;

    localparam int unsigned TREE_LAT  = 6;   // max tree pipeline depth (log2 of lane count)
    localparam int unsigned NUM_LANES = 64;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned INDX_W  = 13;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ENTRY_W = ADDR_W + INDX_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } topk_state_e;

endpackage

// File: rtl/topk_select64_maxtree64.sv
// maxtree64: 64-lane pipelined max tree, one compare level per register stage.
// Stage s loads only when stage s-1 held a valid start token, so the result
// launched by i_start is stable at o_max TREE_LAT cycles later and is held.
// Ties resolve to the left (lower-lane) operand.
module maxtree64 import topk_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned ENT_W      = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [NUM_LANES*ENT_W-1:0] i_lanes,
    output logic [ENT_W-1:0]           o_max
);

    logic [TREE_LAT-1:1] r_vld;
    logic [TREE_LAT:1]   w_en;
    // Heap layout: node n has children 2n and 2n+1; leaves are NUM_LANES..2*NUM_LANES-1.
    logic [ENT_W-1:0]    w_node [1:2*NUM_LANES-1];

    assign w_en = {r_vld, i_start};

    // Token shift register marking which stages hold fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[TREE_LAT-2:1], i_start};
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_leaf
        assign w_node[NUM_LANES+n] = i_lanes[n*ENT_W +: ENT_W];
    end

    for (genvar n = 1; n < NUM_LANES; n++) begin : g_node
        // Node n sits at depth floor(log2 n); the deepest compare level is stage 1.
        localparam int STAGE = TREE_LAT + 1 - $clog2(n + 1);
        logic [ENT_W-1:0] r_q;
        logic [ENT_W-1:0] w_a;
        logic [ENT_W-1:0] w_b;

        assign w_a = w_node[2*n];
        assign w_b = w_node[2*n+1];

        // Pairwise max; >= keeps the lower lane on equal scores.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_en[STAGE]) begin
                r_q <= (w_a[DATA_WIDTH-1:0] >= w_b[DATA_WIDTH-1:0]) ? w_a : w_b;
            end
        end

        assign w_node[n] = r_q;
    end

    assign o_max = w_node[1];

endmodule

// File: rtl/topk_select64.sv
// topk_select64: iterative top-K selector over a 64-lane max tree.
// A batch is banked once; the tree is rerun per rank with already-taken lanes
// masked to the reserved score, so winners emerge in score order.
// Build option TOPK_MIN_EN: scores are inverted on entry and exit, giving
// ascending order with all-ones as the reserved score.
module topk_select64 import topk_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned INDX_WIDTH = INDX_W,
    parameter int unsigned ADDR_WIDTH = ADDR_W
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [6:0]                                      in_k,
    input  logic [NUM_LANES*(INDX_WIDTH+DATA_WIDTH)-1:0]    in_bus,
    output logic                                            res_valid,
    input  logic                                            res_ready,
    output logic [ADDR_WIDTH+INDX_WIDTH+DATA_WIDTH-1:0]     res_entry,
    output logic [5:0]                                      res_rank,
    output logic                                            done,
    output logic [6:0]                                      done_count
);

    localparam int unsigned LANE_W = INDX_WIDTH + DATA_WIDTH;
    localparam int unsigned ENT_W  = ADDR_WIDTH + LANE_W;

`ifdef TOPK_MIN_EN
    localparam logic [DATA_WIDTH-1:0] DATA_XOR = '1;
`else
    localparam logic [DATA_WIDTH-1:0] DATA_XOR = '0;
`endif

    topk_state_e                r_state;
    topk_state_e                w_state_nxt;
    logic [LANE_W-1:0]          r_bank [NUM_LANES];
    logic [NUM_LANES-1:0]       r_mask;
    logic [6:0]                 r_k;
    logic [6:0]                 r_rank;
    logic [6:0]                 r_done_count;
    logic [2:0]                 r_cnt;
    logic [ENT_W-1:0]           r_res_entry;
    logic                       r_in_ready;
    logic                       r_start;
    logic                       r_done;

    logic [NUM_LANES*ENT_W-1:0] w_tree_in;
    logic [ENT_W-1:0]           w_tree_max;
    logic                       w_accept;
    logic                       w_res_fire;
    logic                       w_cnt_done;
    logic                       w_max_empty;
    logic                       w_capture;
    logic [6:0]                 w_rank_inc;
    logic [ADDR_WIDTH-1:0]      w_res_lane;

    assign w_accept    = in_valid & r_in_ready;
    assign w_res_fire  = (r_state == EMIT) & res_ready;
    assign w_cnt_done  = (r_cnt == 3'(TREE_LAT - 1));
    assign w_max_empty = (w_tree_max[DATA_WIDTH-1:0] == '0);
    assign w_capture   = (r_state == WAIT) & w_cnt_done & ~w_max_empty;
    assign w_rank_inc  = r_rank + 7'd1;
    assign w_res_lane  = r_res_entry[ENT_W-1 -: ADDR_WIDTH];

    // Tree feed: lane number is inserted here; masked lanes read as "no candidate".
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_feed
        assign w_tree_in[i*ENT_W +: ENT_W] = {
            ADDR_WIDTH'(i),
            r_bank[i][LANE_W-1 -: INDX_WIDTH],
            r_mask[i] ? {DATA_WIDTH{1'b0}} : r_bank[i][DATA_WIDTH-1:0]
        };
    end

    maxtree64 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENT_W      (ENT_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_start),
        .i_lanes (w_tree_in),
        .o_max   (w_tree_max)
    );

    // Lane bank: captured once per batch, score optionally inverted for min-selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_bank[i] <= {in_bus[i*LANE_W+DATA_WIDTH +: INDX_WIDTH],
                              in_bus[i*LANE_W +: DATA_WIDTH] ^ DATA_XOR};
            end
        end
    end

    // Next-state logic for the per-rank START/WAIT/EMIT loop.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_k == 7'd0) ? DONE : START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                if (w_cnt_done) begin
                    w_state_nxt = w_max_empty ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    w_state_nxt = (w_rank_inc == r_k) ? DONE : START;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and registered strobes derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == IDLE);
            r_start    <= (w_state_nxt == START);
            r_done     <= (w_state_nxt == DONE);
            r_cnt      <= ((r_state == WAIT) && !w_cnt_done) ? r_cnt + 3'd1 : 3'd0;
        end
    end

    // Batch bookkeeping: requested K, current rank and the taken-lane mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_rank <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_k    <= in_k;
            r_rank <= '0;
            r_mask <= '0;
        end else if (w_res_fire) begin
            r_rank             <= w_rank_inc;
            r_mask[w_res_lane] <= 1'b1;
        end
    end

    // Winner capture at the end of the tree latency; score restored to input polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_entry <= '0;
        end else if (w_capture) begin
            r_res_entry <= {w_tree_max[ENT_W-1:DATA_WIDTH],
                            w_tree_max[DATA_WIDTH-1:0] ^ DATA_XOR};
        end
    end

    // Winner count, loaded together with the done pulse and held until the next batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_count <= '0;
        end else if (w_state_nxt == DONE) begin
            if (r_state == EMIT) begin
                r_done_count <= w_rank_inc;
            end else if (r_state == WAIT) begin
                r_done_count <= r_rank;
            end else begin
                r_done_count <= 7'd0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign res_valid  = (r_state == EMIT);
    assign res_entry  = r_res_entry;
    assign res_rank   = r_rank[5:0];
    assign done       = r_done;
    assign done_count = r_done_count;

endmodule

// File: doc/topk_select64.md
# topk_select64

Iterative top-K selector wrapped around the 64-lane pipelined max tree. It accepts one 64-lane batch of {index, score} candidates and reruns the max tree K times, masking each winner after it is taken. The K winners are emitted in descending score order over a valid/ready stream. It sits directly downstream of the per-sample margin scoring and upstream of the sample-index writeback in the margin-sampling datapath.

## Interface
- DATA_WIDTH, 16: score field width.
- INDX_WIDTH, 13: sample index field width.
- ADDR_WIDTH, 6: lane address width (64 lanes).
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  batch offered.
- in_ready  out  1  block idle and able to accept a batch.
- in_k  in  7  number of winners requested (0..64), sampled with the batch.
- in_bus  in  64*(INDX_WIDTH+DATA_WIDTH)  lane i occupies bits [i*29 +: 29], laid out as {indx, data}.
- res_valid  out  1  winner available.
- res_ready  in  1  consumer accepts winner.
- res_entry  out  ADDR_WIDTH+INDX_WIDTH+DATA_WIDTH  {lane, indx, data} of the winner.
- res_rank  out  6  0-based rank of the winner.
- done  out  1  one-cycle pulse when the batch is finished.
- done_count  out  7  winners emitted for the batch; held until the next batch.

## Operation
- Batch capture:
  - On in_valid && in_ready, latch all 64 lanes into the lane bank, latch in_k, and clear the 64-bit lane mask.
  - Each lane's entry is {lane number, indx, data}. The block inserts the lane number itself.
- Tree feed: each tree lane input is the banked entry, with the data field forced to 0 when the lane's mask bit is set.
- Reserved score: data == 0 means "no candidate". A winner with data 0 ends the batch early and is not emitted.
- Ties: on equal scores, the lower lane number wins.
- FSM states:
  - IDLE: in_ready = 1.
    - Accepting a batch with in_k == 0 goes to DONE.
    - Accepting a batch with in_k > 0 goes to START.
  - START: drive tree start for one cycle, then go to WAIT.
  - WAIT: count 6 cycles, then capture the tree max.
    - If the captured data is 0, go to DONE.
    - Otherwise go to EMIT.
  - EMIT: res_valid = 1, with res_entry and res_rank held stable.
    - On res_ready: set the mask bit at res_entry's lane field and increment rank.
    - Then go to DONE if rank == k, otherwise go to START.
  - DONE: pulse done for one cycle, update done_count, go to IDLE.
- A masked lane is never emitted twice within a batch.
- Reset values: in_ready 0 during reset and 1 after; res_valid 0; res_entry 0; res_rank 0; done 0; done_count 0; mask all 0; FSM in IDLE.
- Reset mid-batch: the batch is abandoned. No done pulse is produced.

## Timing
- The start pulse is registered and is high for exactly one cycle, T.
- The tree result is valid in cycle T+6. The FSM samples it at the end of T+6, and res_valid rises in cycle T+7.
- Per-round cost with res_ready held high: 8 cycles (START 1 + WAIT 6 + EMIT 1). A full batch costs 8*K + 2 cycles from accept to done.
- A mask update in EMIT is visible at the tree input before the next START.
- in_ready is 0 from the accept cycle until the cycle after done.
- res_valid, once raised, stays high with stable payload until it is accepted.

## Configuration
- TOPK_MIN_EN defined (select lowest margins):
  - The data field is bitwise inverted at bank entry and inverted again on res_entry.
  - Winners therefore come out in ascending original score.
  - The reserved score becomes all-ones (0xFFFF for 16 bits).
  - Ties still go to the lower lane.
- TOPK_MIN_EN undefined: scores pass straight through, with descending order and reserved 0 as described above.

## Structure
- Shared package topk_pkg holds:
  - TREE_LAT = 6 and NUM_LANES = 64.
  - ENTRY_W = ADDR_WIDTH + INDX_WIDTH + DATA_WIDTH.
  - The FSM state enum {IDLE, START, WAIT, EMIT, DONE}.
- One sub-module instance: maxtree64, fed from the masked bank and driven by the FSM's start.

## Test plan
- Distinct scores, lane i data = i+1, K=3 → entries lane 63/62/61 with data 64/63/62, ranks 0/1/2; done_count = 3; done 26 cycles after accept.
- Tie, lanes 5 and 40 both data 0x0100 (all others 1), K=2 → lane 5 first, lane 40 second.
- Early exhaustion, only lanes 2 and 9 nonzero (0x10, 0x20), K=5 → lane 9, then lane 2, then done with done_count = 2.
- Backpressure, res_ready low for 10 cycles during rank 0 → res_entry stable, no second winner, and the sequence resumes correctly once ready.
- Reset asserted during WAIT of rank 1 → all outputs return to reset values and in_ready = 1 after release; a new batch runs normally.
- TOPK_MIN_EN build, lane i data = 100+i, K=2 → lane 0 (100) then lane 1 (101).
